// File: rtl/sram_port_arbiter.sv
// Two-into-one sram-like port arbiter with an in-order owner-ID FIFO steering data_ok back.
// Latency: request and response paths are combinational pass-through (0 cycles); backpressure: s_req drops when DEPTH are outstanding.
// Optional ARB_RR_EN: round-robin between m0/m1; otherwise fixed priority m0 > m1.
module sram_port_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        aclk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,

    output logic        err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          id_mem [DEPTH];
    logic          lock;
    logic          locked_id;
    logic          prio;
    logic          grant;
    logic          push;
    logic          pop;
    logic          head_id;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

`ifdef ARB_RR_EN
    always_ff @(posedge aclk) begin
        if (reset)
            prio <= 1'b0;
        else if (push)
            prio <= ~grant;
    end
`else
    assign prio = 1'b0;
`endif

    // A locked grant keeps the downstream request stable until it is accepted.
    always_comb begin
        grant = prio;
        if (lock)
            grant = locked_id;
        else if (m0_req && m1_req)
            grant = prio;
        else if (m1_req)
            grant = 1'b1;
        else if (m0_req)
            grant = 1'b0;
    end

    assign s_req   = ~reset & (grant ? m1_req : m0_req) & (count != FULL_CNT);
    assign s_wr    = grant ? m1_wr    : m0_wr;
    assign s_size  = grant ? m1_size  : m0_size;
    assign s_addr  = grant ? m1_addr  : m0_addr;
    assign s_wstrb = grant ? m1_wstrb : m0_wstrb;
    assign s_wdata = grant ? m1_wdata : m0_wdata;

    assign push    = s_req & s_addr_ok;
    assign pop     = ~reset & s_data_ok & (count != '0);
    assign head_id = id_mem[head];

    assign m0_addr_ok = push & ~grant;
    assign m1_addr_ok = push &  grant;
    assign m0_data_ok = pop  & ~head_id;
    assign m1_data_ok = pop  &  head_id;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    always_ff @(posedge aclk) begin
        if (push)
            id_mem[tail] <= grant;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            lock      <= 1'b0;
            locked_id <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (push)
                tail <= ptr_inc(tail);
            if (pop)
                head <= ptr_inc(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // With s_req low (full) the lock is simply held.
            if (s_req) begin
                lock      <= ~s_addr_ok;
                locked_id <= grant;
            end
            if (s_data_ok && count == '0)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (DEPTH=2); expectations adapt to ARB_RR_EN.
module tb_sram_port_arbiter;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [31:0] A0 = 32'h1000_0040;
    localparam logic [31:0] A1 = 32'h2000_0082;
    localparam logic [31:0] W0 = 32'hAAAA_0000;
    localparam logic [31:0] W1 = 32'h0000_5555;

    logic        aclk;
    logic        reset;
    logic        m0_req, m0_wr, m0_addr_ok, m0_data_ok;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_req, m1_wr, m1_addr_ok, m1_data_ok;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port_arbiter #(.DEPTH(2)) dut (
        .aclk(aclk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err(err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        bit rst, r0, r1, aok, dok;
        bit sreq;
        int sel;   // 0: expect m0 fields, 1: m1 fields, 2: not checked
        bit a0, a1, d0, d1, e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit r0, bit r1, bit aok, bit dok,
                                bit sreq, int sel, bit a0, bit a1, bit d0, bit d1, bit e);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.aok = aok; v.dok = dok;
        v.sreq = sreq; v.sel = sel; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit r0, input bit r1, input bit aok,
                         input bit dok, input logic [31:0] rd);
        reset = rst; m0_req = r0; m1_req = r1;
        s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
    endtask

    task automatic check_hs(input string tag, input bit sreq, input bit a0, input bit a1,
                            input bit d0, input bit d1);
        check({tag, " s_req"}, 32'(s_req), 32'(sreq));
        check({tag, " m0_addr_ok"}, 32'(m0_addr_ok), 32'(a0));
        check({tag, " m1_addr_ok"}, 32'(m1_addr_ok), 32'(a1));
        check({tag, " m0_data_ok"}, 32'(m0_data_ok), 32'(d0));
        check({tag, " m1_data_ok"}, 32'(m1_data_ok), 32'(d1));
    endtask

    initial begin
        m0_wr = 1'b0; m0_size = 2'd2; m0_addr = A0; m0_wstrb = 4'hf; m0_wdata = W0;
        m1_wr = 1'b1; m1_size = 2'd1; m1_addr = A1; m1_wstrb = 4'h3; m1_wdata = W1;

        // Reset with both requesting, then continuous traffic.
        tbl.push_back(mk(1,1,1,1,0, 0,2, 0,0,0,0, 0));
        tbl.push_back(mk(1,1,1,1,0, 0,2, 0,0,0,0, 0));
        tbl.push_back(mk(0,1,1,0,0, 1,0, 0,0,0,0, 0));
        tbl.push_back(mk(0,1,1,1,0, 1,0, 1,0,0,0, 0));
        tbl.push_back(mk(0,1,1,1,1, 1,RR?1:0, !RR,RR,1,0, 0));
        tbl.push_back(mk(0,1,1,1,1, 1,0, 1,0,!RR,RR, 0));
        tbl.push_back(mk(0,1,1,1,1, 1,RR?1:0, !RR,RR,1,0, 0));
        tbl.push_back(mk(0,0,0,0,1, 0,2, 0,0,!RR,RR, 0));
        // m1 stalled three cycles, m0 arrives, lock keeps m1.
        tbl.push_back(mk(0,0,1,0,0, 1,1, 0,0,0,0, 0));
        tbl.push_back(mk(0,0,1,0,0, 1,1, 0,0,0,0, 0));
        tbl.push_back(mk(0,0,1,0,0, 1,1, 0,0,0,0, 0));
        tbl.push_back(mk(0,1,1,0,0, 1,1, 0,0,0,0, 0));
        tbl.push_back(mk(0,1,1,1,0, 1,1, 0,1,0,0, 0));
        tbl.push_back(mk(0,1,0,0,1, 1,0, 0,0,0,1, 0));
        tbl.push_back(mk(0,1,0,1,0, 1,0, 1,0,0,0, 0));
        tbl.push_back(mk(0,0,0,0,1, 0,2, 0,0,1,0, 0));

        drive(1,1,1,0,0,32'h0);
        @(posedge aclk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].aok, tbl[i].dok, 32'hC0DE_0000 + 32'(i));
            @(negedge aclk);
            check_hs($sformatf("row%0d", i), tbl[i].sreq, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            check($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].e));
            if (tbl[i].sel != 2)
                check($sformatf("row%0d s_addr", i), s_addr, (tbl[i].sel == 1) ? A1 : A0);
            @(posedge aclk); #1;
        end

        // Fill to DEPTH, observe full, then drain one.
        drive(0,1,0,1,0,32'h0); @(negedge aclk);
        check_hs("fillA", 1,1,0,0,0);
        @(posedge aclk); #1;
        drive(0,0,1,1,0,32'h0); @(negedge aclk);
        check_hs("fillB", 1,0,1,0,0);
        check("fillB s_wr", 32'(s_wr), 32'd1);
        check("fillB s_size", 32'(s_size), 32'd1);
        check("fillB s_wstrb", 32'(s_wstrb), 32'h3);
        check("fillB s_wdata", s_wdata, W1);
        @(posedge aclk); #1;
        drive(0,1,1,1,0,32'h0); @(negedge aclk);
        check_hs("full", 0,0,0,0,0);
        @(posedge aclk); #1;
        drive(0,1,1,1,1,32'h1234_5678); @(negedge aclk);
        check_hs("full_pop", 0,0,0,1,0);
        check("full_pop m0_rdata", m0_rdata, 32'h1234_5678);
        @(posedge aclk); #1;
        drive(0,1,1,0,0,32'h0); @(negedge aclk);
        check_hs("after_pop", 1,0,0,0,0);
        check("after_pop s_addr", s_addr, A0);
        check("after_pop s_wr", 32'(s_wr), 32'd0);
        check("after_pop s_wdata", s_wdata, W0);
        @(posedge aclk); #1;

        // Push and pop together with one outstanding (m1 at head).
        drive(0,1,0,1,1,32'h5A5A_A5A5); @(negedge aclk);
        check_hs("pushpop", 1,1,0,0,1);
        check("pushpop m1_rdata", m1_rdata, 32'h5A5A_A5A5);
        @(posedge aclk); #1;
        drive(0,0,0,0,1,32'h0); @(negedge aclk);
        check_hs("newer_owner", 0,0,0,1,0);
        @(posedge aclk); #1;

        // Completion with nothing outstanding: sticky err until reset.
        drive(0,0,0,0,1,32'h0); @(negedge aclk);
        check_hs("spurious", 0,0,0,0,0);
        check("spurious err_pre", 32'(err), 32'd0);
        @(posedge aclk); #1;
        drive(0,0,0,0,0,32'h0); @(negedge aclk);
        check("err_set", 32'(err), 32'd1);
        @(posedge aclk); #1;
        drive(0,1,0,0,0,32'h0); @(negedge aclk);
        check("err_sticky", 32'(err), 32'd1);
        @(posedge aclk); #1;
        drive(1,1,0,1,0,32'h0); @(negedge aclk);
        check_hs("in_reset", 0,0,0,0,0);
        @(posedge aclk); #1;
        drive(0,0,0,0,0,32'h0); @(negedge aclk);
        check("err_cleared", 32'(err), 32'd0);
        @(posedge aclk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
